// File: rtl/icp_pkg.sv
// Shared types for the MAC result path: lane geometry, the buffered result
// entry and the result-writer FSM states.
package icp_pkg;

   localparam int MU_W  = 18;
   localparam int LANES = 4;

   typedef logic [MU_W-1:0] mu_t;

   typedef struct packed {
      mu_t [LANES-1:0] mu;
      logic            last;
   } entry_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WRITE   = 2'd1,
      RD_WAIT = 2'd2
   } state_t;

endpackage

// File: rtl/result_skid.sv
// Two-entry result buffer: CAP feeds the writer, PEND absorbs one strobe that
// arrives while CAP is still being serialised.
module result_skid
   import icp_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  entry_t            push_data,
   input  logic              mark_last,
   input  logic              pop,
   output mu_t [LANES-1:0]   cap_mu,
   output logic              cap_valid,
   output logic              full,
   output logic              empty,
   output logic              dropped,
   output logic              retire_last
);

   entry_t cap;
   entry_t pend;
   logic   pend_valid;
   entry_t cap_nx;
   entry_t pend_nx;
   logic   cap_valid_nx;
   logic   pend_valid_nx;
   logic   mark_cap;
   logic   mark_pend;

   assign full    = cap_valid & pend_valid;
   assign empty   = ~cap_valid;
   assign dropped = push & full & ~pop;
   assign cap_mu  = cap.mu;

   // A bare done flag tags the newest held entry; if that is CAP retiring now,
   // the tag must still count for this retirement.
   assign mark_cap    = mark_last & cap_valid & ~pend_valid;
   assign mark_pend   = mark_last & pend_valid;
   assign retire_last = pop & (cap.last | mark_cap);

   always_comb begin
      cap_nx        = cap;
      pend_nx       = pend;
      cap_valid_nx  = cap_valid;
      pend_valid_nx = pend_valid;
      if (mark_cap) cap_nx.last = 1'b1;
      if (mark_pend) pend_nx.last = 1'b1;
      if (pop) begin
         cap_nx        = pend_nx;
         cap_valid_nx  = pend_valid;
         pend_valid_nx = 1'b0;
      end
      if (push && !dropped) begin
         if (!cap_valid_nx) begin
            cap_nx       = push_data;
            cap_valid_nx = 1'b1;
         end else begin
            pend_nx       = push_data;
            pend_valid_nx = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap        <= '0;
         pend       <= '0;
         cap_valid  <= 1'b0;
         pend_valid <= 1'b0;
      end else begin
         cap        <= cap_nx;
         pend       <= pend_nx;
         cap_valid  <= cap_valid_nx;
         pend_valid <= pend_valid_nx;
      end
   end

endmodule

// File: rtl/result_writer.sv
// Serialises 4-lane MAC results into a single-port result SRAM and shares that
// port with host read-back whenever no write work is pending.
module result_writer
   import icp_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int RAM_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              web_i,
   input  logic [MU_W-1:0]   mu1_i,
   input  logic [MU_W-1:0]   mu2_i,
   input  logic [MU_W-1:0]   mu3_i,
   input  logic [MU_W-1:0]   mu4_i,
   input  logic              alu_done_i,
   input  logic              start_i,
   input  logic              rd_req_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic [RAM_W-1:0]  ram_dout_i,
   output logic              ram_en_o,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [RAM_W-1:0]  ram_din_o,
   output logic              rd_valid_o,
   output logic [RAM_W-1:0]  rd_data_o,
   output logic              busy_o,
   output logic              job_done_o,
   output logic              wrap_o,
   output logic              overflow_o
);

   localparam int LANE_W = $clog2(LANES);

   function automatic logic [RAM_W-1:0] zext_mu(input mu_t mu);
      return RAM_W'(mu);
   endfunction

   state_t            state;
   state_t            state_nx;
   logic [LANE_W-1:0] lane;
   logic [ADDR_W-1:0] wp;
   logic              done_q;
   logic              wrap_q;
   logic              ovf_q;

   entry_t            push_data;
   mu_t [LANES-1:0]   cap_mu;
   logic              cap_valid;
   logic              full;
   logic              empty;
   logic              dropped;
   logic              retire_last;

   logic              beat;
   logic              pop;
   logic              mark;
   logic              start_ok;
   logic              issue_rd;

   assign push_data = {mu4_i, mu3_i, mu2_i, mu1_i, alu_done_i};
   assign beat      = (state == WRITE);
   assign pop       = beat & (lane == LANE_W'(LANES - 1));
   assign mark      = alu_done_i & ~web_i;
   assign start_ok  = start_i & (state == IDLE) & empty;
   // Reads only get the port when no strobe is waiting or arriving.
   assign issue_rd  = rst & (state == IDLE) & ~cap_valid & ~web_i & rd_req_i;

   result_skid u_skid (
      .clk         (clk),
      .rst         (rst),
      .push        (web_i),
      .push_data   (push_data),
      .mark_last   (mark),
      .pop         (pop),
      .cap_mu      (cap_mu),
      .cap_valid   (cap_valid),
      .full        (full),
      .empty       (empty),
      .dropped     (dropped),
      .retire_last (retire_last)
   );

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (cap_valid || web_i) state_nx = WRITE;
            else if (issue_rd) state_nx = RD_WAIT;
         end
         // PEND occupied (full) or a strobe landing now keeps the beats flowing.
         WRITE:   if (pop && !(full || web_i)) state_nx = IDLE;
         RD_WAIT: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         lane   <= '0;
         wp     <= '0;
         done_q <= 1'b0;
         wrap_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         state  <= state_nx;
         done_q <= retire_last | (mark & empty);
         if (pop) lane <= '0;
         else if (beat) lane <= lane + LANE_W'(1);
         if (start_ok) begin
            wp     <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
         end else begin
            if (beat) begin
               wp <= wp + ADDR_W'(1);
               if (wp == '1) wrap_q <= 1'b1;
            end
            if (dropped) ovf_q <= 1'b1;
         end
      end
   end

   always_comb begin
      ram_en_o   = 1'b0;
      ram_we_o   = 1'b0;
      ram_addr_o = '0;
      ram_din_o  = '0;
      if (beat) begin
         ram_en_o   = 1'b1;
         ram_we_o   = 1'b1;
         ram_addr_o = wp;
         ram_din_o  = zext_mu(cap_mu[lane]);
      end else if (issue_rd) begin
         ram_en_o   = 1'b1;
         ram_addr_o = rd_addr_i;
      end
   end

   assign rd_valid_o = (state == RD_WAIT);
   assign rd_data_o  = rd_valid_o ? ram_dout_i : '0;
   assign busy_o     = beat | cap_valid;
   assign job_done_o = done_q;
   assign wrap_o     = wrap_q;
   assign overflow_o = ovf_q;

endmodule

// File: doc/result_writer.md
# result_writer

Downstream stage of the 4-lane multiply-accumulate ALU. On every result strobe it captures the four 18-bit dot-product results and serialises them, one per cycle, into a single-port result SRAM at consecutive addresses. It signals job completion once the final strobe of a matrix has fully drained. When idle, it arbitrates host read-back of the stored results onto the same SRAM port.

## Interface
- `ADDR_W`, 4: result SRAM address width; 2^ADDR_W words.
- `RAM_W`, 32: SRAM word width; results are zero-extended into it.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `web_i` in 1: result strobe from ALU; `mu1_i..mu4_i` valid in this cycle.
- `mu1_i`, `mu2_i`, `mu3_i`, `mu4_i` in 18 each: lane results.
- `alu_done_i` in 1: final strobe of the job; may coincide with `web_i`.
- `start_i` in 1: new job; clears write pointer and sticky flags.
- `rd_req_i` in 1: host read request.
- `rd_addr_i` in ADDR_W: host read address.
- `ram_dout_i` in RAM_W: SRAM read data, 1-cycle latency.
- `ram_en_o` out 1: SRAM enable.
- `ram_we_o` out 1: SRAM write enable.
- `ram_addr_o` out ADDR_W: SRAM address.
- `ram_din_o` out RAM_W: SRAM write data.
- `rd_valid_o` out 1: `rd_data_o` valid; also the read acknowledge.
- `rd_data_o` out RAM_W: host read data.
- `busy_o` out 1: write beats in progress or buffered.
- `job_done_o` out 1: one-cycle pulse after job drain.
- `wrap_o` out 1: sticky; write pointer wrapped.
- `overflow_o` out 1: sticky; a strobe was dropped.

## Operation
- **Buffer:** 2-entry (CAP, PEND) holding {mu1..mu4, last}.
  - `web_i` loads the first free entry; `last` = `alu_done_i`.
  - If both entries are full, the strobe is dropped and `overflow_o` is set.
  - `alu_done_i` without `web_i` marks the newest occupied entry `last`; if the buffer is empty, it raises `job_done_o` next cycle.
- **FSM states:**
  - **IDLE:**
    - If CAP is valid, go to WRITE.
    - Else if `rd_req_i`, issue the read and go to RD_WAIT.
    - Strobes take priority over reads.
  - **WRITE:**
    - 4 beats, lane 0..3.
    - Each beat: `ram_en_o`=`ram_we_o`=1, `ram_addr_o`=wp, `ram_din_o`={zeros, mu(lane+1)}.
    - wp increments every beat; wrapping 2^ADDR_W-1 to 0 sets `wrap_o`.
    - After lane 3: PEND moves to CAP. Stay in WRITE if CAP is still valid, else go to IDLE.
    - If the retired entry had `last` set, pulse `job_done_o` once the buffer is empty.
  - **RD_WAIT:** one cycle.
    - `rd_valid_o`=1, `rd_data_o`=`ram_dout_i`.
    - Return to IDLE.
- **Read port:**
  - The read is issued combinationally in IDLE: `ram_en_o`=1, `ram_we_o`=0, `ram_addr_o`=`rd_addr_i`.
  - The requester drops `rd_req_i` in the `rd_valid_o` cycle; a request still held is re-accepted as a new read.
  - A `rd_req_i` raised in WRITE waits until IDLE.
- **`start_i`:** honoured only in IDLE with an empty buffer. It clears wp, `wrap_o` and `overflow_o`. Otherwise it is ignored.
- **RAM outputs:** combinational decode of state registers. When inactive: `ram_en_o`=`ram_we_o`=0; `ram_addr_o` and `ram_din_o` are 0.
- **Reset:** state IDLE; wp, buffer, all flags and all outputs 0. A reset mid-WRITE abandons the remaining beats with no further SRAM writes.

## Timing
- Strobe at cycle T in IDLE:
  - write beats in cycles T+1..T+4, addresses wp..wp+3;
  - `busy_o` = 1 in T+1..T+4;
  - `job_done_o` in T+5 if `last`.
- Back-to-back strobes: PEND beats follow immediately, with no idle cycle between them.
- Nominal ALU strobe spacing is 8 cycles, so PEND is never needed in normal operation.
- Read accepted at cycle T: `rd_valid_o` in T+1.
- `busy_o` = (state == WRITE) | CAP valid; registered sources only.

## Structure
- Shared package `icp_pkg`:
  - `MU_W`=18, `LANES`=4;
  - result-entry struct {mu[4], last};
  - FSM state enum {IDLE, WRITE, RD_WAIT}.
- Sub-module `result_skid`: the 2-entry buffer, with push / pop / full / dropped ports.
- Top level holds the FSM, lane counter, wp and read-port mux.

## Test plan
- Reset, then a single strobe with mu=1,2,3,4 and `alu_done_i`=1 -> SRAM addresses 0..3 receive 1,2,3,4 in T+1..T+4; `job_done_o` in T+5 only.
- 4 strobes spaced 8 cycles, `alu_done_i` on the 4th -> addresses 0..15 written in order, `wrap_o`=1, one `job_done_o`.
- Strobes in 3 consecutive cycles -> first two written over 8 consecutive beats; third dropped and `overflow_o`=1; `start_i` in IDLE clears it.
- `rd_req_i` with `rd_addr_i`=5 in the same cycle as `web_i` -> write beats first; read issued at T+5; `rd_valid_o` at T+6 with word 5.
- `rst` low during beat 2 -> no further `ram_we_o`; all outputs 0; next strobe writes from address 0.
- `start_i` asserted in WRITE -> ignored; wp continues incrementing.
